// File: rtl/lc_target_pkg.sv
// Shared types for the life-cycle target sequencer: decoded states, FSM states,
// error codes and the packed target table.
package lc_target_pkg;

  localparam int unsigned NUM_TARGETS_DEF = 5;
  localparam int unsigned STATE_W_DEF     = 6;
  localparam int unsigned TIMEOUT_W_DEF   = 8;

  typedef enum logic [STATE_W_DEF-1:0] {
    LC_ST_0 = STATE_W_DEF'(0),
    LC_ST_1 = STATE_W_DEF'(1),
    LC_ST_2 = STATE_W_DEF'(2),
    LC_ST_3 = STATE_W_DEF'(3),
    LC_ST_4 = STATE_W_DEF'(4)
  } ext_dec_lc_state_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_PROG  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_ORDER = 2'b10,
    ERR_PROG  = 2'b11
  } err_code_e;

  typedef logic [NUM_TARGETS_DEF-1:0][STATE_W_DEF-1:0] lc_target_table_t;

endpackage

// File: rtl/lc_target_table.sv
// Reset-initialised, read-only target table (entry i holds value i) with an
// indexed combinational read and an out-of-range flag.
module lc_target_table
  import lc_target_pkg::*;
#(
  parameter int unsigned NUM_TARGETS = NUM_TARGETS_DEF,
  parameter int unsigned STATE_W     = STATE_W_DEF,
  parameter int unsigned IDX_W       = $clog2(NUM_TARGETS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [STATE_W-1:0] rd_state_c,
  output logic               rd_oor_c
);

  logic [NUM_TARGETS-1:0][STATE_W-1:0] table_d, table_q;

  always_comb begin
    table_d = table_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
        table_q[i] <= STATE_W'(i);
      end
    end else begin
      table_q <= table_d;
    end
  end

  // Decoded read so indices past the last entry never select a table row.
  always_comb begin
    rd_state_c = '0;
    rd_oor_c   = (32'(rd_idx_i) >= NUM_TARGETS);
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (32'(rd_idx_i) == i) begin
        rd_state_c = table_q[i];
      end
    end
  end

endmodule

// File: rtl/lc_target_sequencer.sv
// Life-cycle transition sequencer: range/forward check, program handshake and
// committed-state tracking. Define LC_TARGET_SEQ_TIMEOUT_EN to add a program timeout.
module lc_target_sequencer
  import lc_target_pkg::*;
#(
  parameter int unsigned NUM_TARGETS = NUM_TARGETS_DEF,
  parameter int unsigned STATE_W     = STATE_W_DEF,
  parameter int unsigned TIMEOUT_W   = TIMEOUT_W_DEF,
  localparam int unsigned IDX_W      = $clog2(NUM_TARGETS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [IDX_W-1:0]   req_idx_i,
  output logic               prog_valid_o,
  output logic [STATE_W-1:0] prog_state_o,
  input  logic               prog_ack_i,
  input  logic               prog_err_i,
  output logic [STATE_W-1:0] state_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [1:0]         err_code_o
);

  if (NUM_TARGETS < 2 || TIMEOUT_W == 0) begin : g_param_check
    $error("lc_target_sequencer: NUM_TARGETS must be >= 2 and TIMEOUT_W >= 1");
  end

  seq_state_e         state_d, state_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic               prog_valid_d, prog_valid_q;
  logic [STATE_W-1:0] prog_state_d, prog_state_q;
  logic [STATE_W-1:0] cur_state_d, cur_state_q;
  logic               done_d, done_q;
  logic               err_d, err_q;
  err_code_e          err_code_d, err_code_q;
  logic [STATE_W-1:0] rd_state;
  logic               rd_oor;
  logic               timeout_c;

  lc_target_table #(
    .NUM_TARGETS (NUM_TARGETS),
    .STATE_W     (STATE_W),
    .IDX_W       (IDX_W)
  ) u_table (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rd_idx_i   (idx_q),
    .rd_state_c (rd_state),
    .rd_oor_c   (rd_oor)
  );

`ifdef LC_TARGET_SEQ_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt_d, cnt_q;

  // Counter reads 0 on the first PROG cycle; expiry fires as it would reach all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_CHECK) begin
      cnt_d = '0;
    end else if (state_q == ST_PROG) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_c = (state_q == ST_PROG) && (cnt_q == TO_LAST);
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    prog_valid_d = prog_valid_q;
    prog_state_d = prog_state_q;
    cur_state_d  = cur_state_q;
    done_d       = 1'b0;
    err_d        = err_q;
    err_code_d   = err_code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d    = ST_CHECK;
          idx_d      = req_idx_i;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end
      ST_CHECK: begin
        if (rd_oor) begin
          state_d    = ST_ERR;
          err_code_d = ERR_RANGE;
        end else if (rd_state <= cur_state_q) begin
          state_d    = ST_ERR;
          err_code_d = ERR_ORDER;
        end else begin
          state_d      = ST_PROG;
          prog_valid_d = 1'b1;
          prog_state_d = rd_state;
        end
      end
      // Error beats ack; ack beats timeout.
      ST_PROG: begin
        if (prog_err_i) begin
          state_d      = ST_ERR;
          err_code_d   = ERR_PROG;
          prog_valid_d = 1'b0;
        end else if (prog_ack_i) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          prog_valid_d = 1'b0;
        end else if (timeout_c) begin
          state_d      = ST_ERR;
          err_code_d   = ERR_PROG;
          prog_valid_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        cur_state_d = prog_state_q;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      prog_valid_q <= 1'b0;
      prog_state_q <= '0;
      cur_state_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      prog_valid_q <= prog_valid_d;
      prog_state_q <= prog_state_d;
      cur_state_q  <= cur_state_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign prog_valid_o = prog_valid_q;
  assign prog_state_o = prog_state_q;
  assign state_o      = cur_state_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_lc_target_sequencer.sv
// Directed + randomized bench for lc_target_sequencer with a transaction-level
// reference model of the check rules and committed state.
module tb_lc_target_sequencer;

  localparam int unsigned NT = 5;
  localparam int unsigned SW = 6;
  localparam int unsigned TW = 4;
  localparam int unsigned IW = $clog2(NT);

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [IW-1:0] req_idx_i;
  logic          prog_valid_o;
  logic [SW-1:0] prog_state_o;
  logic          prog_ack_i;
  logic          prog_err_i;
  logic [SW-1:0] state_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [1:0]    err_code_o;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int unsigned model_state = 0;

  lc_target_sequencer #(
    .NUM_TARGETS (NT),
    .STATE_W     (SW),
    .TIMEOUT_W   (TW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_idx_i    (req_idx_i),
    .prog_valid_o (prog_valid_o),
    .prog_state_o (prog_state_o),
    .prog_ack_i   (prog_ack_i),
    .prog_err_i   (prog_err_i),
    .state_o      (state_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done_o === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outcome of a request from the rules: 0 = success, else the error code.
  function automatic int unsigned expect_code(input int unsigned idx, input int unsigned cur,
                                              input int unsigned mode);
    if (idx >= NT) return 1;
    if (idx <= cur) return 2;
    return (mode == 0) ? 0 : 3;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, ":prog_valid"}, 32'(prog_valid_o), 0);
    chk({tag, ":prog_state"}, 32'(prog_state_o), 0);
    chk({tag, ":state"}, 32'(state_o), 0);
    chk({tag, ":done"}, 32'(done_o), 0);
    chk({tag, ":err"}, 32'(err_o), 0);
    chk({tag, ":err_code"}, 32'(err_code_o), 0);
    chk({tag, ":busy"}, 32'(busy_o), 0);
    chk({tag, ":ready"}, 32'(req_ready_o), 1);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    model_state = 0;
  endtask

  // mode: 0 = ack, 1 = err, 2 = ack and err together
  task automatic run_txn(input int unsigned idx, input int unsigned dly,
                         input int unsigned mode, input string tag);
    int unsigned code;
    int d0;
    code = expect_code(idx, model_state, mode);
    chk({tag, ":ready"}, 32'(req_ready_o), 1);
    req_valid_i = 1'b1;
    req_idx_i   = IW'(idx);
    step();
    req_valid_i = 1'b0;
    d0 = done_cnt;
    chk({tag, ":busy_check"}, 32'(busy_o), 1);
    chk({tag, ":err_cleared"}, 32'(err_o), 0);
    step();
    if (code == 1 || code == 2) begin
      chk({tag, ":no_prog"}, 32'(prog_valid_o), 0);
      step();
      chk({tag, ":err"}, 32'(err_o), 1);
      chk({tag, ":code"}, 32'(err_code_o), code);
      chk({tag, ":state_kept"}, 32'(state_o), model_state);
      chk({tag, ":ready_after"}, 32'(req_ready_o), 1);
    end else begin
      chk({tag, ":prog_valid"}, 32'(prog_valid_o), 1);
      chk({tag, ":prog_state"}, 32'(prog_state_o), idx);
      for (int i = 0; i < int'(dly); i++) begin
        step();
        chk({tag, ":prog_hold"}, {31'(prog_state_o), prog_valid_o}, {31'(idx), 1'b1});
      end
      prog_ack_i = (mode != 1);
      prog_err_i = (mode != 0);
      step();
      prog_ack_i = 1'b0;
      prog_err_i = 1'b0;
      chk({tag, ":prog_drop"}, 32'(prog_valid_o), 0);
      if (code == 0) begin
        chk({tag, ":done"}, 32'(done_o), 1);
        step();
        chk({tag, ":done_pulse"}, 32'(done_o), 0);
        chk({tag, ":state_new"}, 32'(state_o), idx);
        chk({tag, ":err_none"}, 32'(err_o), 0);
        chk({tag, ":ready_after"}, 32'(req_ready_o), 1);
        model_state = idx;
      end else begin
        step();
        chk({tag, ":err"}, 32'(err_o), 1);
        chk({tag, ":code"}, 32'(err_code_o), 3);
        chk({tag, ":state_kept"}, 32'(state_o), model_state);
        chk({tag, ":ready_after"}, 32'(req_ready_o), 1);
      end
    end
    chk({tag, ":done_count"}, 32'(done_cnt - d0), (code == 0) ? 1 : 0);
  endtask

  initial begin
    int unsigned ridx, rdly, rmode;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_idx_i   = '0;
    prog_ack_i  = 1'b0;
    prog_err_i  = 1'b0;
    step();
    step();
    chk_reset_vals("reset");
    rst_ni = 1'b1;
    step();

    run_txn(3, 2, 0, "fwd3");
    run_txn(2, 0, 0, "back2");
    run_txn(4, 1, 2, "ack_err_both");

    // Out-of-range request held valid; the second index is taken once idle.
    req_valid_i = 1'b1;
    req_idx_i   = IW'(7);
    step();
    chk("held:busy", 32'(busy_o), 1);
    step();
    chk("held:not_ready", 32'(req_ready_o), 0);
    step();
    chk("held:err", 32'(err_o), 1);
    chk("held:code", 32'(err_code_o), 1);
    chk("held:ready", 32'(req_ready_o), 1);
    req_idx_i = IW'(4);
    step();
    req_valid_i = 1'b0;
    chk("held:reaccept_busy", 32'(busy_o), 1);
    chk("held:err_cleared", 32'(err_o), 0);
    chk("held:code_cleared", 32'(err_code_o), 0);
    step();
    chk("held:prog_state", 32'(prog_state_o), 4);
    prog_ack_i = 1'b1;
    step();
    prog_ack_i = 1'b0;
    chk("held:done", 32'(done_o), 1);
    step();
    chk("held:state", 32'(state_o), 4);
    model_state = 4;

    // Ack/err while idle must be ignored.
    prog_ack_i = 1'b1;
    prog_err_i = 1'b1;
    step();
    step();
    prog_ack_i = 1'b0;
    prog_err_i = 1'b0;
    chk("idle_ack:busy", 32'(busy_o), 0);
    chk("idle_ack:err", 32'(err_o), 0);
    chk("idle_ack:state", 32'(state_o), model_state);

    // Program never acknowledged.
    do_reset();
    req_valid_i = 1'b1;
    req_idx_i   = IW'(1);
    step();
    req_valid_i = 1'b0;
    step();
    chk("noack:prog_valid", 32'(prog_valid_o), 1);
`ifdef LC_TARGET_SEQ_TIMEOUT_EN
    repeat (14) step();
    chk("timeout:still_prog", 32'(prog_valid_o), 1);
    step();
    chk("timeout:prog_drop", 32'(prog_valid_o), 0);
    chk("timeout:busy_err", 32'(busy_o), 1);
    step();
    chk("timeout:err", 32'(err_o), 1);
    chk("timeout:code", 32'(err_code_o), 3);
    chk("timeout:state", 32'(state_o), 0);
`else
    repeat (100) step();
    chk("noack:busy", 32'(busy_o), 1);
    chk("noack:prog_held", 32'(prog_valid_o), 1);
    prog_ack_i = 1'b1;
    step();
    prog_ack_i = 1'b0;
    chk("noack:done", 32'(done_o), 1);
    step();
    chk("noack:state", 32'(state_o), 1);
    model_state = 1;
`endif

    // Reset in the middle of PROG.
    req_valid_i = 1'b1;
    req_idx_i   = IW'(3);
    step();
    req_valid_i = 1'b0;
    step();
    chk("midrst:prog_valid", 32'(prog_valid_o), 1);
    rst_ni = 1'b0;
    step();
    chk_reset_vals("midrst");
    rst_ni = 1'b1;
    model_state = 0;
    step();
    chk("midrst:no_done", 32'(done_o), 0);
    chk("midrst:no_err", 32'(err_o), 0);

    for (int n = 0; n < 40; n++) begin
      if (model_state == NT - 1) begin
        do_reset();
        step();
        chk("rand:reset_state", 32'(state_o), 0);
      end
      ridx  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                                          : $urandom_range(model_state + 1, NT - 1);
      rdly  = $urandom_range(0, 3);
      rmode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      run_txn(ridx, rdly, rmode, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
